// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between the core port (c_*)
// and the loader/debug port (l_*). Requests are served one at a time through
// an IDLE -> ACCESS -> RESP sequence. Arbitration is round-robin, and the
// loader may hold a bounded lock.
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata        core request (held until c_ack)
//   c_ack                            one-cycle core completion pulse
//   l_req/l_we/l_addr/l_wdata/l_lock loader request and lock hint
//   l_ack                            one-cycle loader completion pulse
//   rdata                            read data, valid with the ack
//   m_addr/m_wdata/m_we/m_rdata      registered memory port, 1-cycle read latency
//   grant                            owner: 00 none, 01 core, 10 loader
//   busy                             high while in ACCESS or RESP
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t            state;
  logic              lastLoader;
  logic              ownerWrite;
  logic [LOCK_W-1:0] lockCnt;

  logic cElig;
  logic lElig;
  logic lockHold;
  logic doGrant;
  logic pickLoader;

  // Winner selection. The ack mask hides a request that is still high in
  // its own ack cycle. While the loader holds an unexpired lock and keeps
  // requesting, the core is not granted. The loader's ack cycle then idles
  // for one cycle, so the lock survives the masked cycle.
  always_comb begin
    cElig      = c_req & ~c_ack;
    lElig      = l_req & ~l_ack;
    lockHold   = lastLoader & l_lock & l_req & (lockCnt < LOCK_W'(MAX_LOCK));
    doGrant    = 1'b0;
    pickLoader = 1'b0;
    if (lockHold) begin
      doGrant    = lElig;
      pickLoader = 1'b1;
    end else begin
      doGrant    = cElig | lElig;
      pickLoader = lElig & (~cElig | ~lastLoader);
    end
  end

  // Sequencer with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lastLoader <= 1'b1;
      ownerWrite <= 1'b0;
      lockCnt    <= '0;
      c_ack      <= 1'b0;
      l_ack      <= 1'b0;
      rdata      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_we       <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (!l_lock) lockCnt <= '0;
          if (doGrant) begin
            state <= ACCESS;
            busy  <= 1'b1;
            if (pickLoader) begin
              m_addr     <= l_addr;
              m_wdata    <= l_wdata;
              m_we       <= l_we;
              ownerWrite <= l_we;
              grant      <= 2'b10;
              if (l_lock && (lockCnt < LOCK_W'(MAX_LOCK)))
                lockCnt <= lockCnt + LOCK_W'(1);
            end else begin
              m_addr     <= c_addr;
              m_wdata    <= c_wdata;
              m_we       <= c_we;
              ownerWrite <= c_we;
              grant      <= 2'b01;
              lockCnt    <= '0;
            end
          end
        end
        ACCESS: begin
          m_we  <= 1'b0;
          state <= RESP;
        end
        RESP: begin
          if (!ownerWrite) rdata <= m_rdata;
          c_ack      <= (grant == 2'b01);
          l_ack      <= (grant == 2'b10);
          lastLoader <= (grant == 2'b10);
          grant      <= 2'b00;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
          m_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single unified instruction/data memory of the multicycle RISC-V core between the core's memory port and the program loader/debug port. It serialises accesses through a three-state sequencer, registers address, data and write-enable toward the memory, and returns read data with a one-cycle acknowledge. Arbitration is round-robin. The loader may hold a bounded lock for burst program loading.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LOCK, 16, max consecutive locked loader grants before the core must be served
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- c_req  in  1  core request; held until c_ack
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_ack  out  1  one-cycle completion pulse to core
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as core
- l_lock  in  1  loader requests to keep ownership across transactions
- l_ack  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data, valid in the c_ack/l_ack cycle
- m_addr  out  ADDR_W  memory address (registered)
- m_wdata  out  DATA_W  memory write data (registered)
- m_we  out  1  memory write strobe (registered)
- m_rdata  in  DATA_W  memory read data, synchronous one-cycle latency
- grant  out  2  current owner: 00 none, 01 core, 10 loader
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE(00), ACCESS(01), RESP(10); encoding 11 is illegal and returns to IDLE.
- IDLE: evaluate eligible requests. A request is eligible when its req=1 and its own ack is not high this cycle, which masks the stale req in the ack cycle.
  - No eligible request: stay in IDLE.
  - Otherwise pick the winner, latch its addr/wdata/we into m_addr/m_wdata/m_we, set grant, and go to ACCESS.
- Winner selection:
  - Only one eligible: it wins.
  - Both eligible: the requester not served last wins.
  - Lock override: if last = loader, l_lock=1 and lock_cnt < MAX_LOCK, the loader wins.
- ACCESS: memory performs the write, or launches the read. Go to RESP and drop m_we, so m_we is high exactly one cycle.
- RESP: m_rdata is valid.
  - Register rdata <= m_rdata for reads. rdata holds its previous value for writes.
  - Set the owner's ack for the next cycle.
  - Update last := owner, clear grant, go to IDLE.
- lock_cnt (width covering MAX_LOCK):
  - Increments on a loader grant with l_lock=1.
  - Clears on any core grant, and whenever l_lock=0 in IDLE.
  - Saturates at MAX_LOCK.
- A requester dropping req or changing addr/wdata mid-transaction does not affect the transaction. It completes with the latched values and the ack still pulses.
- Reset:
  - Outputs: c_ack=0, l_ack=0, rdata=0, m_addr=0, m_wdata=0, m_we=0, grant=00, busy=0.
  - Internal: state=IDLE, last=loader (core wins the first tie), lock_cnt=0.
  - Reset mid-transaction aborts it with no ack. A write in ACCESS is not retried.

## Timing
- Request seen in IDLE at cycle N:
  - Cycle N+1: ACCESS, m_addr/m_we valid.
  - Cycle N+2: RESP.
  - Cycle N+3: ack=1 and rdata valid.
- Latency from req to ack is 3 cycles when uncontended.
- The ack cycle is also an IDLE cycle, so the other requester can be granted in N+3. The next transaction's ACCESS is at N+4, giving peak throughput of one access per 3 cycles.
- Requester rules: hold req until ack; deassert in the cycle after ack, or keep it high to issue a new request, which is eligible from the cycle after ack.
- Worst-case core wait with the loader locked is MAX_LOCK transactions plus the one in flight.

## Test plan
- Single core read: c_req=1, c_addr=0x40, memory holds 0xDEADBEEF at 0x40 → m_addr=0x40 at N+1, c_ack=1 and rdata=0xDEADBEEF at N+3, l_ack stays 0.
- Single loader write: l_we=1, l_addr=0x10, l_wdata=0x1234 → m_we=1 for exactly one cycle at N+1 with m_wdata=0x1234, l_ack at N+3, memory[0x10]=0x1234.
- Simultaneous requests after reset, both held → grants in order core, loader, core, loader; acks at N+3, N+6, N+9, N+12.
- Loader locked burst (MAX_LOCK=4), l_lock=1, both requesting continuously → 4 loader grants, then 1 core grant, then the loader resumes. grant never shows core while lock_cnt<4.
- Stale-request mask: core keeps c_req=1 for one cycle after c_ack with the loader idle → no duplicate grant in the ack cycle; the next core grant is in the following cycle only if c_req is still high.
- Reset mid-transaction: rst=0 during ACCESS → next cycle state=IDLE, m_we=0, grant=00, no ack ever issued for the aborted request.
